// File: rtl/dual_port_memory.sv
// Two-port word memory with per-lane byte enables, optional output register
// stage and a post-reset zero-fill sequencer that holds off accesses while busy.
module dual_port_memory #(
  parameter int WORD_SIZE      = 24,
  parameter int N_WORDS        = 512,
  parameter int LANE_W         = 8,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int N_LANES       = WORD_SIZE / LANE_W,
  localparam int AW            = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_en,
  input  logic                 b_en,
  input  logic                 a_we,
  input  logic                 b_we,
  input  logic [N_LANES-1:0]   a_be,
  input  logic [N_LANES-1:0]   b_be,
  input  logic [AW-1:0]        a_addr,
  input  logic [AW-1:0]        b_addr,
  input  logic [WORD_SIZE-1:0] a_din,
  input  logic [WORD_SIZE-1:0] b_din,
  output logic [WORD_SIZE-1:0] a_dout,
  output logic [WORD_SIZE-1:0] b_dout,
  output logic                 a_valid,
  output logic                 b_valid,
  output logic                 busy,
  output logic                 collision
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic [WORD_SIZE-1:0]   mem_q [N_WORDS];

  logic                   a_acc, b_acc, a_inr, b_inr;
  logic [AW-1:0]          a_idx, b_idx;
  logic [N_LANES-1:0]     a_wl, b_wl;
  logic [WORD_SIZE-1:0]   a_rd, b_rd;
  logic [WORD_SIZE-1:0]   a_dout1_q, a_dout1_d, b_dout1_q, b_dout1_d;
  logic                   a_valid1_q, a_valid1_d, b_valid1_q, b_valid1_d;
  logic                   collision_q, collision_d;

  // Word a port returns: old word, or own written lanes merged over it when
  // RDW_MODE=1; out-of-range addresses read as zero.
  function automatic logic [WORD_SIZE-1:0] rd_word(
    input logic [WORD_SIZE-1:0] old,
    input logic [WORD_SIZE-1:0] din,
    input logic [N_LANES-1:0]   be,
    input logic                 we,
    input logic                 inr
  );
    logic [WORD_SIZE-1:0] w;
    w = old;
    for (int i = 0; i < N_LANES; i++) begin
      if ((RDW_MODE == 1) && we && be[i]) begin
        w[i*LANE_W +: LANE_W] = din[i*LANE_W +: LANE_W];
      end else begin
        w[i*LANE_W +: LANE_W] = old[i*LANE_W +: LANE_W];
      end
    end
    return inr ? w : {WORD_SIZE{1'b0}};
  endfunction

  // Clear sequencer next state: walk every address once, then go ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == AW'(N_WORDS - 1)) begin
          state_d = READY;
          cnt_d   = {AW{1'b0}};
        end else begin
          cnt_d   = cnt_q + AW'(1);
        end
      end
      READY:   state_d = READY;
      default: state_d = READY;
    endcase
    busy_d = (state_d == CLEAR);
  end

  // Clear sequencer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt_q   <= {AW{1'b0}};
      busy_q  <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Access decode: accesses are dropped while clearing or in reset.
  always_comb begin
    a_acc = a_en & ~busy_q & ~reset;
    b_acc = b_en & ~busy_q & ~reset;
    a_inr = ({1'b0, a_addr} < (AW+1)'(N_WORDS));
    b_inr = ({1'b0, b_addr} < (AW+1)'(N_WORDS));
    a_idx = a_inr ? a_addr : {AW{1'b0}};
    b_idx = b_inr ? b_addr : {AW{1'b0}};
    a_wl  = {N_LANES{a_acc & a_we & a_inr}} & a_be;
    b_wl  = {N_LANES{b_acc & b_we & b_inr}} & b_be;
    a_rd  = rd_word(mem_q[a_idx], a_din, a_be, a_we, a_inr);
    b_rd  = rd_word(mem_q[b_idx], b_din, b_be, b_we, b_inr);
  end

  // Storage: port A is applied after port B so it wins shared lanes.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == CLEAR)) begin
      mem_q[cnt_q] <= {WORD_SIZE{1'b0}};
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        if (b_wl[i]) mem_q[b_idx][i*LANE_W +: LANE_W] <= b_din[i*LANE_W +: LANE_W];
        if (a_wl[i]) mem_q[a_idx][i*LANE_W +: LANE_W] <= a_din[i*LANE_W +: LANE_W];
      end
    end
  end

  // First read stage; dout holds between accesses.
  always_comb begin
    a_dout1_d   = a_acc ? a_rd : a_dout1_q;
    b_dout1_d   = b_acc ? b_rd : b_dout1_q;
    a_valid1_d  = a_acc;
    b_valid1_d  = b_acc;
    collision_d = a_acc & b_acc & a_we & b_we & (a_addr == b_addr);
  end

  // First read stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_dout1_q   <= {WORD_SIZE{1'b0}};
      b_dout1_q   <= {WORD_SIZE{1'b0}};
      a_valid1_q  <= 1'b0;
      b_valid1_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      a_dout1_q   <= a_dout1_d;
      b_dout1_q   <= b_dout1_d;
      a_valid1_q  <= a_valid1_d;
      b_valid1_q  <= b_valid1_d;
      collision_q <= collision_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WORD_SIZE-1:0] a_dout2_q, a_dout2_d, b_dout2_q, b_dout2_d;
      logic                 a_valid2_q, b_valid2_q;

      // Second stage captures only fresh data so dout still holds when idle.
      always_comb begin
        a_dout2_d = a_valid1_q ? a_dout1_q : a_dout2_q;
        b_dout2_d = b_valid1_q ? b_dout1_q : b_dout2_q;
      end

      // Second read stage registers; advances every cycle.
      always_ff @(posedge clk) begin
        if (reset) begin
          a_dout2_q  <= {WORD_SIZE{1'b0}};
          b_dout2_q  <= {WORD_SIZE{1'b0}};
          a_valid2_q <= 1'b0;
          b_valid2_q <= 1'b0;
        end else begin
          a_dout2_q  <= a_dout2_d;
          b_dout2_q  <= b_dout2_d;
          a_valid2_q <= a_valid1_q;
          b_valid2_q <= b_valid1_q;
        end
      end

      assign a_dout  = a_dout2_q;
      assign b_dout  = b_dout2_q;
      assign a_valid = a_valid2_q;
      assign b_valid = b_valid2_q;
    end else begin : g_no_out_reg
      assign a_dout  = a_dout1_q;
      assign b_dout  = b_dout1_q;
      assign a_valid = a_valid1_q;
      assign b_valid = b_valid1_q;
    end
  endgenerate

  assign busy      = busy_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_dual_port_memory.sv
// Scoreboard bench: dut0 uses defaults, dut1 uses RDW_MODE=1, OUT_REG=1,
// N_WORDS=300; both share stimulus, each has its own expected queues.
module tb_dual_port_memory;

  typedef struct {
    logic [23:0] d;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_en, b_en, a_we, b_we;
  logic [2:0]  a_be, b_be;
  logic [8:0]  a_addr, b_addr;
  logic [23:0] a_din, b_din;

  logic [23:0] d0_a_dout, d0_b_dout, d1_a_dout, d1_b_dout;
  logic        d0_a_valid, d0_b_valid, d1_a_valid, d1_b_valid;
  logic        d0_busy, d1_busy, d0_coll, d1_coll;

  exp_t q0a[$], q0b[$], q1a[$], q1b[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dual_port_memory u_dut0 (
    .clk(clk), .reset(reset),
    .a_en(a_en), .b_en(b_en), .a_we(a_we), .b_we(b_we),
    .a_be(a_be), .b_be(b_be), .a_addr(a_addr), .b_addr(b_addr),
    .a_din(a_din), .b_din(b_din), .a_dout(d0_a_dout), .b_dout(d0_b_dout),
    .a_valid(d0_a_valid), .b_valid(d0_b_valid), .busy(d0_busy), .collision(d0_coll)
  );

  dual_port_memory #(.N_WORDS(300), .RDW_MODE(1), .OUT_REG(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .a_en(a_en), .b_en(b_en), .a_we(a_we), .b_we(b_we),
    .a_be(a_be), .b_be(b_be), .a_addr(a_addr), .b_addr(b_addr),
    .a_din(a_din), .b_din(b_din), .a_dout(d1_a_dout), .b_dout(d1_b_dout),
    .a_valid(d1_a_valid), .b_valid(d1_b_valid), .busy(d1_busy), .collision(d1_coll)
  );

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void pop_chk(string nm, logic [23:0] dout, exp_t e, int lat);
    check({nm, " data"}, {8'd0, dout}, {8'd0, e.d});
    check({nm, " latency"}, cyc - e.c, lat);
  endfunction

  // Monitor: every valid pulse pops one expectation and checks data and latency.
  always @(negedge clk) begin
    if (d0_a_valid === 1'b1) begin
      if (q0a.size() == 0) check("d0a spurious valid", {31'd0, d0_a_valid}, 32'd0);
      else pop_chk("d0a", d0_a_dout, q0a.pop_front(), 1);
    end
    if (d0_b_valid === 1'b1) begin
      if (q0b.size() == 0) check("d0b spurious valid", {31'd0, d0_b_valid}, 32'd0);
      else pop_chk("d0b", d0_b_dout, q0b.pop_front(), 1);
    end
    if (d1_a_valid === 1'b1) begin
      if (q1a.size() == 0) check("d1a spurious valid", {31'd0, d1_a_valid}, 32'd0);
      else pop_chk("d1a", d1_a_dout, q1a.pop_front(), 2);
    end
    if (d1_b_valid === 1'b1) begin
      if (q1b.size() == 0) check("d1b spurious valid", {31'd0, d1_b_valid}, 32'd0);
      else pop_chk("d1b", d1_b_dout, q1b.pop_front(), 2);
    end
  end

  // One cycle of stimulus on both ports; ea*/eb* are the expected returns for dut0/dut1.
  task automatic issue(
    input logic aen, awe, input logic [2:0] abe, input logic [8:0] aad,
    input logic [23:0] adi, ea0, ea1,
    input logic ben, bwe, input logic [2:0] bbe, input logic [8:0] bad_,
    input logic [23:0] bdi, eb0, eb1
  );
    a_en = aen; a_we = awe; a_be = abe; a_addr = aad; a_din = adi;
    b_en = ben; b_we = bwe; b_be = bbe; b_addr = bad_; b_din = bdi;
    if (aen) begin
      q0a.push_back('{ea0, cyc});
      q1a.push_back('{ea1, cyc});
    end
    if (ben) begin
      q0b.push_back('{eb0, cyc});
      q1b.push_back('{eb1, cyc});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0 = 0;
    int n1 = 0;
    reset = 1'b1;
    a_en = 1'b0; a_we = 1'b0; a_be = 3'b000; a_addr = 9'd0; a_din = 24'd0;
    b_en = 1'b0; b_we = 1'b0; b_be = 3'b000; b_addr = 9'd0; b_din = 24'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy0", {31'd0, d0_busy}, 32'd1);
    check("reset busy1", {31'd0, d1_busy}, 32'd1);
    check("reset dout", {8'd0, d0_a_dout | d0_b_dout | d1_a_dout | d1_b_dout}, 32'd0);
    check("reset valid", {28'd0, d0_a_valid, d0_b_valid, d1_a_valid, d1_b_valid}, 32'd0);
    check("reset collision", {30'd0, d0_coll, d1_coll}, 32'd0);

    // Start clearing with accesses requested; they must be ignored.
    reset = 1'b0;
    a_en = 1'b1; a_we = 1'b1; a_be = 3'b111; a_addr = 9'd3; a_din = 24'h5A5A5A;
    b_en = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid-clear reset busy0", {31'd0, d0_busy}, 32'd1);
    check("mid-clear reset busy1", {31'd0, d1_busy}, 32'd1);
    reset = 1'b0;
    a_en = 1'b0; b_en = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (d0_busy) n0++;
      if (d1_busy) n1++;
      if (!d0_busy && !d1_busy) break;
    end
    check("clear cycles dut0", n0, 32'd512);
    check("clear cycles dut1", n1, 32'd300);
    @(posedge clk); #1;

    // Cleared contents and the dut1 out-of-range read of 511.
    issue(1'b1, 1'b0, 3'b111, 9'd0,   24'h0, 24'h0, 24'h0,   1'b1, 1'b0, 3'b111, 9'd255, 24'h0, 24'h0, 24'h0);
    issue(1'b1, 1'b0, 3'b111, 9'd511, 24'h0, 24'h0, 24'h0,   1'b1, 1'b0, 3'b111, 9'd299, 24'h0, 24'h0, 24'h0);
    // Byte enables; dut1 returns merged new data on writes.
    issue(1'b1, 1'b1, 3'b111, 9'd5, 24'hAABBCC, 24'h000000, 24'hAABBCC, 1'b0, 1'b0, 3'b000, 9'd0, 24'h0, 24'h0, 24'h0);
    issue(1'b1, 1'b1, 3'b010, 9'd5, 24'h112233, 24'hAABBCC, 24'hAA22CC, 1'b0, 1'b0, 3'b000, 9'd0, 24'h0, 24'h0, 24'h0);
    issue(1'b1, 1'b0, 3'b111, 9'd5, 24'h000000, 24'hAA22CC, 24'hAA22CC, 1'b0, 1'b0, 3'b000, 9'd0, 24'h0, 24'h0, 24'h0);
    // Read-during-write on the same port.
    issue(1'b1, 1'b1, 3'b111, 9'd7, 24'h000001, 24'h000000, 24'h000001, 1'b0, 1'b0, 3'b000, 9'd0, 24'h0, 24'h0, 24'h0);
    issue(1'b1, 1'b1, 3'b111, 9'd7, 24'h000002, 24'h000001, 24'h000002, 1'b0, 1'b0, 3'b000, 9'd0, 24'h0, 24'h0, 24'h0);
    issue(1'b1, 1'b0, 3'b111, 9'd7, 24'h000000, 24'h000002, 24'h000002, 1'b0, 1'b0, 3'b000, 9'd0, 24'h0, 24'h0, 24'h0);
    // Same-address dual write with partially overlapping lanes.
    issue(1'b1, 1'b1, 3'b110, 9'd9, 24'h111111, 24'h000000, 24'h111100,
          1'b1, 1'b1, 3'b011, 9'd9, 24'h222222, 24'h000000, 24'h002222);
    check("collision dut0", {31'd0, d0_coll}, 32'd1);
    check("collision dut1", {31'd0, d1_coll}, 32'd1);
    // A writes while B reads the same address: B sees the old word.
    issue(1'b1, 1'b1, 3'b111, 9'd9, 24'h333333, 24'h111122, 24'h333333,
          1'b1, 1'b0, 3'b111, 9'd9, 24'h000000, 24'h111122, 24'h111122);
    check("no collision dut0", {31'd0, d0_coll}, 32'd0);
    check("no collision dut1", {31'd0, d1_coll}, 32'd0);
    issue(1'b0, 1'b0, 3'b000, 9'd0, 24'h0, 24'h0, 24'h0,     1'b1, 1'b0, 3'b111, 9'd9, 24'h0, 24'h333333, 24'h333333);
    // Boundary: 310 is in range for dut0 only; 299 is the last dut1 word.
    issue(1'b1, 1'b1, 3'b111, 9'd310, 24'hABCDEF, 24'h000000, 24'h000000,
          1'b1, 1'b1, 3'b101, 9'd299, 24'h445566, 24'h000000, 24'h440066);
    issue(1'b1, 1'b0, 3'b111, 9'd310, 24'h000000, 24'hABCDEF, 24'h000000,
          1'b1, 1'b0, 3'b111, 9'd299, 24'h000000, 24'h440066, 24'h440066);
    issue(1'b0, 1'b0, 3'b000, 9'd0, 24'h0, 24'h0, 24'h0,     1'b0, 1'b0, 3'b000, 9'd0, 24'h0, 24'h0, 24'h0);
    repeat (4) @(posedge clk);
    #1;
    check("dut0 a_dout holds", {8'd0, d0_a_dout}, 32'hABCDEF);
    check("dut1 b_dout holds", {8'd0, d1_b_dout}, 32'h440066);
    check("scoreboard drained", q0a.size() + q0b.size() + q1a.size() + q1b.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_port_memory.md
DUAL_PORT_MEMORY -- requirements
Module: dual_port_memory

Interface
REQ-001 SHALL provide parameter WORD_SIZE, default 24: data word width in bits.
REQ-002 SHALL provide parameter N_WORDS, default 512: number of words; need not be a power of two.
REQ-003 SHALL provide parameter LANE_W, default 8: byte-enable lane width; WORD_SIZE is a multiple of LANE_W; N_LANES = WORD_SIZE/LANE_W.
REQ-004 SHALL provide parameter RDW_MODE, default 0: same-port read-during-write; 0 = old data, 1 = new data.
REQ-005 SHALL provide parameter OUT_REG, default 0: 1 adds one output register stage.
REQ-006 SHALL provide parameter CLEAR_ON_RESET, default 1: 1 zero-fills memory after reset.
REQ-007 SHALL provide one clock and a synchronous, active-high reset; all logic on posedge clk.
REQ-008 SHALL provide the following ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
a_en, b_en  in  1  port access request
a_we, b_we  in  1  write (1) / read (0) when en=1
a_be, b_be  in  N_LANES  per-lane write enable
a_addr, b_addr  in  $clog2(N_WORDS)  word address
a_din, b_din  in  WORD_SIZE  write data
a_dout, b_dout  out  WORD_SIZE  read data
a_valid, b_valid  out  1  one-cycle pulse, read data valid
busy  out  1  clear in progress, accesses ignored
collision  out  1  one-cycle pulse, same-address dual write

Function
REQ-009 SHALL accept one access per port per cycle when en=1 and busy=0; SHALL ignore en while busy=1 (no write, no valid).
REQ-010 SHALL write only lanes with be[i]=1; lanes with be[i]=0 retain prior contents.
REQ-011 SHALL treat every en=1 access (read or write) as a read: dout/valid after latency L = 1 + OUT_REG cycles.
REQ-012 SHALL pulse valid for exactly one cycle per accepted access; dout holds its last value otherwise.
REQ-013 With RDW_MODE=0, a write access SHALL return the pre-write word; with RDW_MODE=1, the written lanes merged with old unwritten lanes.
REQ-014 A read on one port to the address written by the other port in the same cycle SHALL return the old word regardless of RDW_MODE.
REQ-015 Simultaneous writes to the same address SHALL resolve per lane: port A wins on lanes both enable; lanes enabled by only one port take that port's data.
REQ-016 SHALL pulse collision at cycle t+1 for a same-address dual write at cycle t, even if be lanes do not overlap.
REQ-017 Address >= N_WORDS SHALL be ignored on write and SHALL return 0 on read, with valid still pulsed.
REQ-018 Clear FSM SHALL have states CLEAR and READY; CLEAR writes 0 to address cnt, cnt increments each cycle, N_WORDS-1 -> READY.
REQ-019 busy SHALL equal 1 exactly while in CLEAR; clear SHALL take exactly N_WORDS cycles.
REQ-020 With CLEAR_ON_RESET=0, FSM SHALL go straight to READY; memory contents undefined until written.
REQ-021 Pipeline stages for OUT_REG=1 SHALL advance every cycle; no backpressure.

Reset
REQ-022 While reset=1: a_dout=b_dout=0, a_valid=b_valid=0, collision=0, in-flight reads discarded.
REQ-023 While reset=1: busy=1 and cnt=0 if CLEAR_ON_RESET=1, else busy=0.
REQ-024 Reset asserted mid-clear SHALL restart clear from address 0; reset SHALL NOT alter memory contents by itself.
REQ-025 First cycle after reset deasserts with CLEAR_ON_RESET=1 SHALL write address 0.

Verification
REQ-026 Clear: reset 1 cycle, defaults -> busy=1 for exactly 512 cycles; then reads of 0, 255, 511 return 0x000000.
REQ-027 Byte enables: write 0xAABBCC to addr 5 be=111, then 0x112233 be=010 -> read addr 5 returns 0xAA22CC with a_valid at t+1.
REQ-028 RDW: RDW_MODE=0, addr 7 holds 0x000001, port A writes 0x000002 -> a_dout=0x000001; RDW_MODE=1 -> 0x000002; next read 0x000002 both modes.
REQ-029 Dual write: A writes 0x111111 be=110, B writes 0x222222 be=011 to addr 9 -> collision pulse at t+1, addr 9 reads 0x111122; B reading A's write address same cycle returns old data.
REQ-030 Latency/boundary: OUT_REG=1, N_WORDS=300, read addr 299 -> valid at t+2; write to addr 310 ignored, read 310 returns 0 with valid.
REQ-031 Reset mid-clear: reset at clear cycle 100 -> busy restarts; exactly 512 further cycles of busy; in-flight valid suppressed.
